// File: rtl/watch_mode_sched.sv
// Mode select, front-panel request arbitration (clr > ss > mode, one grant per edge) and stopwatch/timer sequencing.
// All outputs are registered on clk1sec; timer expiry overrides any grant and forces the timer view until silenced.
module watch_mode_sched #(
  parameter int unsigned IDLE_SECS  = 30,
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       clk1sec,
  input  logic       rst,
  input  logic       mode_req,
  input  logic       ss_req,
  input  logic       clr_req,
  input  logic       timer_zero,
  output logic       mode_ack,
  output logic       ss_ack,
  output logic       clr_ack,
  output logic [1:0] sel,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       tm_run,
  output logic       tm_load,
  output logic       alarm
);
  typedef enum logic [1:0] {CLOCK = 2'b00, STOPWATCH = 2'b01, TIMER = 2'b10} mode_e;
  typedef enum logic {SW_STOP = 1'b0, SW_RUN = 1'b1} sw_e;
  typedef enum logic [1:0] {TM_IDLE, TM_RUN, TM_PAUSE, TM_EXPIRED} tm_e;

  localparam logic [5:0] IDLE_LIM  = 6'(IDLE_SECS);
  localparam logic [5:0] ALARM_LIM = 6'(ALARM_SECS);

  mode_e      mode_q, mode_d;
  sw_e        sw_q, sw_d;
  tm_e        tm_q, tm_d;
  logic [5:0] idle_cnt_q, idle_cnt_d;
  logic [5:0] alarm_cnt_q, alarm_cnt_d;
  logic       mode_ack_q, mode_ack_d;
  logic       ss_ack_q, ss_ack_d;
  logic       clr_ack_q, clr_ack_d;
  logic       sw_clear_q, sw_clear_d;
  logic       tm_run_q, tm_run_d;
  logic       tm_load_q, tm_load_d;
  logic       alarm_q, alarm_d;

  logic       expire, clr_gnt, ss_gnt, mode_gnt, any_gnt, idle_ok;
  logic [5:0] idle_inc;

  // Expiry takes the edge outright; a request held across it is granted on a later edge.
  assign expire   = (tm_q == TM_RUN) && timer_zero;
  assign clr_gnt  = !expire && clr_req && !clr_ack_q;
  assign ss_gnt   = !expire && !clr_gnt && ss_req && !ss_ack_q;
  assign mode_gnt = !expire && !clr_gnt && !ss_gnt && mode_req && !mode_ack_q;
  assign any_gnt  = clr_gnt || ss_gnt || mode_gnt;

  assign idle_ok = (mode_q != CLOCK) && !any_gnt && !expire &&
                   ((mode_q != STOPWATCH) || (sw_q == SW_STOP)) &&
                   ((mode_q != TIMER) || (tm_q == TM_IDLE) || (tm_q == TM_PAUSE));
  assign idle_inc = idle_cnt_q + 6'd1;

  always_comb begin
    mode_d      = mode_q;
    sw_d        = sw_q;
    tm_d        = tm_q;
    idle_cnt_d  = '0;
    alarm_cnt_d = alarm_cnt_q;
    mode_ack_d  = mode_gnt;
    ss_ack_d    = ss_gnt;
    clr_ack_d   = clr_gnt;
    sw_clear_d  = 1'b0;
    tm_load_d   = 1'b0;
    alarm_d     = 1'b0;

    if (idle_ok) begin
      if (idle_inc == IDLE_LIM) mode_d = CLOCK;
      else                      idle_cnt_d = idle_inc;
    end

    if (expire) begin
      tm_d        = TM_EXPIRED;
      mode_d      = TIMER;
      alarm_d     = 1'b1;
      alarm_cnt_d = 6'd1;
    end else if (tm_q == TM_EXPIRED) begin
      // Any grant while expired only silences the alarm.
      if (any_gnt || (alarm_cnt_q == ALARM_LIM)) begin
        tm_d        = TM_IDLE;
        tm_load_d   = 1'b1;
        alarm_cnt_d = '0;
      end else begin
        alarm_d     = !alarm_q;
        alarm_cnt_d = alarm_cnt_q + 6'd1;
      end
    end else if (clr_gnt) begin
      case (mode_q)
        STOPWATCH: begin
          sw_clear_d = 1'b1;
          sw_d       = SW_STOP;
        end
        TIMER: begin
          tm_load_d = 1'b1;
          tm_d      = TM_IDLE;
        end
        default: ;
      endcase
    end else if (ss_gnt) begin
      case (mode_q)
        STOPWATCH: sw_d = (sw_q == SW_RUN) ? SW_STOP : SW_RUN;
        TIMER: begin
          case (tm_q)
            TM_IDLE:  if (!timer_zero) tm_d = TM_RUN;
            TM_RUN:   tm_d = TM_PAUSE;
            TM_PAUSE: tm_d = TM_RUN;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end else if (mode_gnt) begin
      case (mode_q)
        CLOCK:     mode_d = STOPWATCH;
        STOPWATCH: mode_d = TIMER;
        default:   mode_d = CLOCK;
      endcase
    end

    tm_run_d = (tm_d == TM_RUN);
  end

  always_ff @(posedge clk1sec or posedge rst) begin
    if (rst) begin
      mode_q      <= CLOCK;
      sw_q        <= SW_STOP;
      tm_q        <= TM_IDLE;
      idle_cnt_q  <= '0;
      alarm_cnt_q <= '0;
      mode_ack_q  <= 1'b0;
      ss_ack_q    <= 1'b0;
      clr_ack_q   <= 1'b0;
      sw_clear_q  <= 1'b0;
      tm_run_q    <= 1'b0;
      tm_load_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      sw_q        <= sw_d;
      tm_q        <= tm_d;
      idle_cnt_q  <= idle_cnt_d;
      alarm_cnt_q <= alarm_cnt_d;
      mode_ack_q  <= mode_ack_d;
      ss_ack_q    <= ss_ack_d;
      clr_ack_q   <= clr_ack_d;
      sw_clear_q  <= sw_clear_d;
      tm_run_q    <= tm_run_d;
      tm_load_q   <= tm_load_d;
      alarm_q     <= alarm_d;
    end
  end

  assign mode_ack = mode_ack_q;
  assign ss_ack   = ss_ack_q;
  assign clr_ack  = clr_ack_q;
  assign sel      = mode_q;
  assign sw_run   = (sw_q == SW_RUN);
  assign sw_clear = sw_clear_q;
  assign tm_run   = tm_run_q;
  assign tm_load  = tm_load_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_watch_mode_sched.sv
// Scoreboarded directed bench for watch_mode_sched: stimulus queues the expected output word for the next edge,
// a monitor pops it half a cycle later (or just after an asynchronous reset) and compares.
`timescale 1ns/1ps
module tb_watch_mode_sched;
  logic       clk1sec = 1'b0;
  logic       rst = 1'b0;
  logic       mode_req = 1'b0, ss_req = 1'b0, clr_req = 1'b0, timer_zero = 1'b0;
  logic       mode_ack, ss_ack, clr_ack;
  logic [1:0] sel;
  logic       sw_run, sw_clear, tm_run, tm_load, alarm;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];
  string      tag_q[$];

  watch_mode_sched #(.IDLE_SECS(30), .ALARM_SECS(10)) dut (
    .clk1sec(clk1sec), .rst(rst),
    .mode_req(mode_req), .ss_req(ss_req), .clr_req(clr_req), .timer_zero(timer_zero),
    .mode_ack(mode_ack), .ss_ack(ss_ack), .clr_ack(clr_ack), .sel(sel),
    .sw_run(sw_run), .sw_clear(sw_clear), .tm_run(tm_run), .tm_load(tm_load), .alarm(alarm)
  );

  always #5 clk1sec = ~clk1sec;

  // Word layout: {mode_ack, ss_ack, clr_ack, sel, sw_run, sw_clear, tm_run, tm_load, alarm}
  function automatic logic [9:0] ex(input logic [2:0] acks, input logic [1:0] s, input logic [4:0] rest);
    return {acks, s, rest};
  endfunction

  task automatic expect_out(input logic [9:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // in = {mode_req, ss_req, clr_req, timer_zero}; e is the output word after the following edge.
  task automatic step(input logic [3:0] in, input logic [9:0] e, input string tag);
    @(negedge clk1sec);
    #2;
    {mode_req, ss_req, clr_req, timer_zero} = in;
    expect_out(e, tag);
  endtask

  initial begin : monitor
    logic [9:0] act;
    logic [9:0] e;
    string      t;
    forever begin
      @(negedge clk1sec or posedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        act = {mode_ack, ss_ack, clr_ack, sel, sw_run, sw_clear, tm_run, tm_load, alarm};
        tests++;
        if (act !== e) begin
          fails++;
          $display("FAIL %s: got %b, required %b", t, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    #2;
    expect_out(10'b0, "reset_values");
    rst = 1'b1;
    @(negedge clk1sec);
    #2;
    rst = 1'b0;

    // Mode rotation, one-cycle acks
    step(4'b1000, ex(3'b100, 2'b01, 5'b00000), "mode_to_sw");
    step(4'b0000, ex(3'b000, 2'b01, 5'b00000), "sw_hold");
    step(4'b1000, ex(3'b100, 2'b10, 5'b00000), "mode_to_tm");
    step(4'b0000, ex(3'b000, 2'b10, 5'b00000), "tm_hold");
    step(4'b1000, ex(3'b100, 2'b00, 5'b00000), "mode_to_clk");
    step(4'b0000, ex(3'b000, 2'b00, 5'b00000), "clk_hold");
    step(4'b1000, ex(3'b100, 2'b01, 5'b00000), "mode_to_sw2");
    step(4'b0000, ex(3'b000, 2'b01, 5'b00000), "sw_hold2");

    // clr beats ss; ss served next edge
    step(4'b0110, ex(3'b001, 2'b01, 5'b01000), "clr_wins");
    step(4'b0100, ex(3'b010, 2'b01, 5'b10000), "ss_pending");
    step(4'b0000, ex(3'b000, 2'b01, 5'b10000), "sw_running");

    // Timer run / pause / resume with stopwatch still running
    step(4'b1000, ex(3'b100, 2'b10, 5'b10000), "mode_keeps_sw");
    step(4'b0000, ex(3'b000, 2'b10, 5'b10000), "tm_view");
    step(4'b0100, ex(3'b010, 2'b10, 5'b10100), "tm_start");
    step(4'b0000, ex(3'b000, 2'b10, 5'b10100), "tm_running");
    step(4'b0100, ex(3'b010, 2'b10, 5'b10000), "tm_pause");
    step(4'b0001, ex(3'b000, 2'b10, 5'b10000), "zero_in_pause");
    step(4'b0100, ex(3'b010, 2'b10, 5'b10100), "tm_resume");
    step(4'b0000, ex(3'b000, 2'b10, 5'b10100), "tm_running2");

    // Expiry with full-length alarm and auto exit
    step(4'b0001, ex(3'b000, 2'b10, 5'b10001), "expire");
    for (int k = 1; k <= 9; k++)
      step(4'b0001, ex(3'b000, 2'b10, (k % 2 == 0) ? 5'b10001 : 5'b10000), "alarm_pattern");
    step(4'b0001, ex(3'b000, 2'b10, 5'b10010), "alarm_auto_exit");
    step(4'b0001, ex(3'b000, 2'b10, 5'b10000), "alarm_off");
    step(4'b0101, ex(3'b010, 2'b10, 5'b10000), "start_at_zero");
    step(4'b0000, ex(3'b000, 2'b10, 5'b10000), "idle_hold");

    // Silence by mode_req during alarm
    step(4'b0100, ex(3'b010, 2'b10, 5'b10100), "tm_start2");
    step(4'b0001, ex(3'b000, 2'b10, 5'b10001), "expire2");
    step(4'b1001, ex(3'b100, 2'b10, 5'b10010), "silence_mode");
    step(4'b0000, ex(3'b000, 2'b10, 5'b10000), "after_silence");

    // Expiry and request on the same edge
    step(4'b0100, ex(3'b010, 2'b10, 5'b10100), "tm_start3");
    step(4'b1001, ex(3'b000, 2'b10, 5'b10001), "expire_beats_gnt");
    step(4'b1001, ex(3'b100, 2'b10, 5'b10010), "late_silence");
    step(4'b0000, ex(3'b000, 2'b10, 5'b10000), "after_silence2");

    // Held request ignored while its ack is high; then idle return from stopped stopwatch
    step(4'b1000, ex(3'b100, 2'b00, 5'b10000), "mode_to_clk2");
    step(4'b1000, ex(3'b000, 2'b00, 5'b10000), "held_req_ignored");
    step(4'b1000, ex(3'b100, 2'b01, 5'b10000), "mode_to_sw3");
    step(4'b0100, ex(3'b010, 2'b01, 5'b00000), "sw_stop");
    for (int k = 1; k <= 29; k++)
      step(4'b0000, ex(3'b000, 2'b01, 5'b00000), "idle_count");
    step(4'b0000, ex(3'b000, 2'b00, 5'b00000), "idle_return");

    // Running stopwatch blocks idle return
    step(4'b1000, ex(3'b100, 2'b01, 5'b00000), "mode_to_sw4");
    step(4'b0100, ex(3'b010, 2'b01, 5'b10000), "sw_start");
    for (int k = 1; k <= 40; k++)
      step(4'b0000, ex(3'b000, 2'b01, 5'b10000), "no_idle_when_running");

    // Asynchronous reset mid-alarm with held mode_req
    step(4'b1000, ex(3'b100, 2'b10, 5'b10000), "mode_to_tm2");
    step(4'b0100, ex(3'b010, 2'b10, 5'b10100), "tm_start4");
    step(4'b0001, ex(3'b000, 2'b10, 5'b10001), "expire3");
    step(4'b0001, ex(3'b000, 2'b10, 5'b10000), "alarm_e1");
    step(4'b0001, ex(3'b000, 2'b10, 5'b10001), "alarm_e2");
    @(negedge clk1sec);
    #2;
    {mode_req, ss_req, clr_req, timer_zero} = 4'b1000;
    expect_out(10'b0, "async_reset");
    rst = 1'b1;
    @(negedge clk1sec);
    #2;
    rst = 1'b0;
    expect_out(ex(3'b100, 2'b01, 5'b00000), "ack_after_reset");
    step(4'b0000, ex(3'b000, 2'b01, 5'b00000), "post_reset");

    @(negedge clk1sec);
    @(negedge clk1sec);
    #3;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
